d8m_vga_timing: RTL and testbench

//   Raster timing generator driving the D8M camera read-out/display path. Produces
//   VGA_HS/VGA_VS, blanking, H_Cont/V_Cont and READ_Request, the line-buffer read

---
 rtl/d8m_vga_pkg.sv | 27 ++
 rtl/vga_axis_timing.sv | 63 ++++++
 rtl/d8m_vga_timing.sv | 81 ++++++++
 tb/tb_d8m_vga_timing.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/d8m_vga_pkg.sv
// rtl/d8m_vga_pkg.sv - 640x480@60 raster constants and window helpers shared by the camera stages
package d8m_vga_pkg;
    localparam int CW      = 13;
    localparam int CNT_MAX = 8191;

    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_H_ACT     = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_V_ACT     = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_READ_LEAD = 2;

    function automatic int total_of(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    function automatic int start_of(input int sync, input int bp);
        return sync + bp;
    endfunction

    function automatic int end_of(input int sync, input int bp, input int act);
        return sync + bp + act;
    endfunction
endpackage

// File: rtl/vga_axis_timing.sv
// rtl/vga_axis_timing.sv - one raster axis: wrapping counter, sync and window decodes
module vga_axis_timing
    import d8m_vga_pkg::*;
#(
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP   = DEF_H_BP,
    parameter int ACT  = DEF_H_ACT,
    parameter int FP   = DEF_H_FP,
    parameter int LEAD = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_step,
    output logic [CW-1:0] o_cnt,
    output logic          o_wrap,
    output logic          o_sync_n,
    output logic          o_act_next,
    output logic          o_lead_next
);
    localparam int TOTAL = total_of(SYNC, BP, ACT, FP);
    localparam int START = start_of(SYNC, BP);
    localparam int STOP  = end_of(SYNC, BP, ACT);

    localparam logic [CW-1:0] L_LAST   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] L_SYNC   = CW'(SYNC);
    localparam logic [CW-1:0] L_START  = CW'(START);
    localparam logic [CW-1:0] L_END    = CW'(STOP);
    localparam logic [CW-1:0] L_LSTART = CW'(START - LEAD);
    localparam logic [CW-1:0] L_LEND   = CW'(STOP - LEAD);

    if (TOTAL > CNT_MAX) begin : g_bad_total
        $error("axis total exceeds counter range");
    end

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next;
    logic          r_sync_n;

    always_comb begin
        w_next = r_cnt;
        if (i_step) begin
            w_next = (r_cnt == L_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // Decodes look at the next count so registered outputs move with the counter
    assign o_wrap      = i_step && (r_cnt == L_LAST);
    assign o_act_next  = (w_next >= L_START) && (w_next < L_END);
    assign o_lead_next = (w_next >= L_LSTART) && (w_next < L_LEND);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_sync_n <= 1'b0;
        end else begin
            r_cnt    <= w_next;
            r_sync_n <= (w_next >= L_SYNC);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_sync_n = r_sync_n;
endmodule

// File: rtl/d8m_vga_timing.sv
// rtl/d8m_vga_timing.sv - raster timing with line-buffer read strobe leading active video
module d8m_vga_timing
    import d8m_vga_pkg::*;
#(
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int H_ACT     = DEF_H_ACT,
    parameter int H_FP      = DEF_H_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int V_ACT     = DEF_V_ACT,
    parameter int V_FP      = DEF_V_FP,
    parameter int READ_LEAD = DEF_READ_LEAD
) (
    input  logic          VGA_CLK,
    input  logic          RESET,
    output logic [CW-1:0] H_Cont,
    output logic [CW-1:0] V_Cont,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          READ_Request,
    output logic          oFRAME_START
);
    if (READ_LEAD < 0 || READ_LEAD > H_BP) begin : g_bad_lead
        $error("READ_LEAD must lie in 0..H_BP");
    end

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_h_act;
    logic w_v_act;
    logic w_h_lead;
    logic w_v_lead;
    logic r_blank_n;
    logic r_read;
    logic r_frame;

    vga_axis_timing #(
        .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP), .LEAD(READ_LEAD)
    ) u_h (
        .i_clk      (VGA_CLK),
        .i_rst      (RESET),
        .i_step     (1'b1),
        .o_cnt      (H_Cont),
        .o_wrap     (w_h_wrap),
        .o_sync_n   (VGA_HS),
        .o_act_next (w_h_act),
        .o_lead_next(w_h_lead)
    );

    // Vertical read window is not shifted, so its lead decode equals its active decode
    vga_axis_timing #(
        .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP), .LEAD(0)
    ) u_v (
        .i_clk      (VGA_CLK),
        .i_rst      (RESET),
        .i_step     (w_h_wrap),
        .o_cnt      (V_Cont),
        .o_wrap     (w_v_wrap),
        .o_sync_n   (VGA_VS),
        .o_act_next (w_v_act),
        .o_lead_next(w_v_lead)
    );

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            r_blank_n <= 1'b0;
            r_read    <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_blank_n <= w_h_act && w_v_act;
            r_read    <= w_h_lead && w_v_lead;
            r_frame   <= w_h_wrap && w_v_wrap;
        end
    end

    assign VGA_BLANK_N  = r_blank_n;
    assign READ_Request = r_read;
    assign oFRAME_START = r_frame;
endmodule

// File: tb/tb_d8m_vga_timing.sv
// tb/tb_d8m_vga_timing.sv - scoreboard bench for d8m_vga_timing at full and reduced raster sizes
module tb_d8m_vga_timing;
    localparam int DH_T = 800;
    localparam int DV_T = 525;
    localparam int SH_T = 18;
    localparam int SV_T = 11;

    logic        clk   = 1'b0;
    logic        rst_d = 1'b1;
    logic        rst_s = 1'b1;
    logic [12:0] d_h, d_v, s_h, s_v, z_h, z_v;
    logic        d_hs, d_vs, d_bl, d_rr, d_fs;
    logic        s_hs, s_vs, s_bl, s_rr, s_fs;
    logic        z_hs, z_vs, z_bl, z_rr, z_fs;
    logic [30:0] obs_d, obs_s, obs_z;
    logic [30:0] q_d[$];
    logic [30:0] q_s[$];
    logic [30:0] q_z[$];
    int          md_h = 0, md_v = 0, ms_h = 0, ms_v = 0;
    int          errors = 0, checks = 0;

    assign obs_d = {d_h, d_v, d_hs, d_vs, d_bl, d_rr, d_fs};
    assign obs_s = {s_h, s_v, s_hs, s_vs, s_bl, s_rr, s_fs};
    assign obs_z = {z_h, z_v, z_hs, z_vs, z_bl, z_rr, z_fs};

    always #5 clk = ~clk;

    d8m_vga_timing u_dut (
        .VGA_CLK(clk), .RESET(rst_d), .H_Cont(d_h), .V_Cont(d_v), .VGA_HS(d_hs), .VGA_VS(d_vs),
        .VGA_BLANK_N(d_bl), .READ_Request(d_rr), .oFRAME_START(d_fs)
    );

    d8m_vga_timing #(
        .H_SYNC(4), .H_BP(4), .H_ACT(8), .H_FP(2), .V_SYNC(2), .V_BP(3), .V_ACT(4), .V_FP(2), .READ_LEAD(2)
    ) u_sml (
        .VGA_CLK(clk), .RESET(rst_s), .H_Cont(s_h), .V_Cont(s_v), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_bl), .READ_Request(s_rr), .oFRAME_START(s_fs)
    );

    d8m_vga_timing #(
        .H_SYNC(4), .H_BP(4), .H_ACT(8), .H_FP(2), .V_SYNC(2), .V_BP(3), .V_ACT(4), .V_FP(2), .READ_LEAD(0)
    ) u_zero (
        .VGA_CLK(clk), .RESET(rst_s), .H_Cont(z_h), .V_Cont(z_v), .VGA_HS(z_hs), .VGA_VS(z_vs),
        .VGA_BLANK_N(z_bl), .READ_Request(z_rr), .oFRAME_START(z_fs)
    );

    function automatic logic [30:0] expect_vec(input int h, input int v, input logic fs,
                                               input int hsy, input int hbp, input int hac,
                                               input int vsy, input int vbp, input int vac,
                                               input int lead);
        logic vin, hs, vs, bl, rr;
        vin = (v >= vsy + vbp) && (v < vsy + vbp + vac);
        hs  = (h >= hsy);
        vs  = (v >= vsy);
        bl  = vin && (h >= hsy + hbp) && (h < hsy + hbp + hac);
        rr  = vin && (h >= hsy + hbp - lead) && (h < hsy + hbp + hac - lead);
        return {13'(h), 13'(v), hs, vs, bl, rr, fs};
    endfunction

    // Drives one clock and pushes what each instance must show after that edge
    task automatic tick(input logic rd, input logic rs);
        logic fs;
        rst_d = rd;
        rst_s = rs;
        if (rd) begin
            md_h = 0; md_v = 0;
            q_d.push_back('0);
        end else begin
            fs = (md_h == DH_T - 1) && (md_v == DV_T - 1);
            if (md_h == DH_T - 1) begin
                md_h = 0;
                md_v = (md_v == DV_T - 1) ? 0 : md_v + 1;
            end else begin
                md_h++;
            end
            q_d.push_back(expect_vec(md_h, md_v, fs, 96, 48, 640, 2, 33, 480, 2));
        end
        if (rs) begin
            ms_h = 0; ms_v = 0;
            q_s.push_back('0);
            q_z.push_back('0);
        end else begin
            fs = (ms_h == SH_T - 1) && (ms_v == SV_T - 1);
            if (ms_h == SH_T - 1) begin
                ms_h = 0;
                ms_v = (ms_v == SV_T - 1) ? 0 : ms_v + 1;
            end else begin
                ms_h++;
            end
            q_s.push_back(expect_vec(ms_h, ms_v, fs, 4, 4, 8, 2, 3, 4, 2));
            q_z.push_back(expect_vec(ms_h, ms_v, fs, 4, 4, 8, 2, 3, 4, 0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [30:0] e;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            e = q_d.pop_front(); checks++;
            if (obs_d !== e) begin errors++; $display("FAIL reset_d cyc%0d got %h want %h", i, obs_d, e); end
            e = q_s.pop_front(); checks++;
            if (obs_s !== e) begin errors++; $display("FAIL reset_s cyc%0d got %h want %h", i, obs_s, e); end
            e = q_z.pop_front(); checks++;
            if (obs_z !== e) begin errors++; $display("FAIL reset_z cyc%0d got %h want %h", i, obs_z, e); end
        end
        tick(1'b0, 1'b0);
        e = q_d.pop_front(); checks++;
        if (obs_d !== e) begin errors++; $display("FAIL release_d got %h want %h", obs_d, e); end
        e = q_s.pop_front(); checks++;
        if (obs_s !== e) begin errors++; $display("FAIL release_s got %h want %h", obs_s, e); end
        q_z.delete();
        checks++;
        if (d_h !== 13'd1) begin errors++; $display("FAIL release_h got %0d want 1", d_h); end
    endtask

    task automatic test_run_to_line();
        logic [30:0] e;
        for (int i = 0; i < 40000 && !(md_h == DH_T - 1 && md_v == 39); i++) begin
            tick(1'b0, 1'b0);
            e = q_d.pop_front(); checks++;
            if (obs_d !== e) begin errors++; $display("FAIL run_d at (%0d,%0d) got %h want %h", md_h, md_v, obs_d, e); end
            e = q_s.pop_front(); checks++;
            if (obs_s !== e) begin errors++; $display("FAIL run_s at (%0d,%0d) got %h want %h", ms_h, ms_v, obs_s, e); end
            q_z.delete();
        end
    endtask

    task automatic test_line();
        logic [30:0] e;
        int hs_lo = 0, hs_last = -1, bl_n = 0, bl_first = -1, bl_last = -1, rr_n = 0, rr_first = -1, rr_last = -1;
        for (int i = 0; i < DH_T; i++) begin
            tick(1'b0, 1'b0);
            e = q_d.pop_front(); checks++;
            if (obs_d !== e) begin errors++; $display("FAIL line_d at (%0d,%0d) got %h want %h", md_h, md_v, obs_d, e); end
            q_s.delete(); q_z.delete();
            if (d_hs === 1'b0) begin hs_lo++; hs_last = int'(d_h); end
            if (d_bl === 1'b1) begin bl_n++; bl_last = int'(d_h); if (bl_first < 0) bl_first = int'(d_h); end
            if (d_rr === 1'b1) begin rr_n++; rr_last = int'(d_h); if (rr_first < 0) rr_first = int'(d_h); end
        end
        checks++; if (hs_lo != 96)    begin errors++; $display("FAIL hs_width got %0d want 96", hs_lo); end
        checks++; if (hs_last != 95)  begin errors++; $display("FAIL hs_last got %0d want 95", hs_last); end
        checks++; if (bl_n != 640)    begin errors++; $display("FAIL blank_width got %0d want 640", bl_n); end
        checks++; if (bl_first != 144) begin errors++; $display("FAIL blank_first got %0d want 144", bl_first); end
        checks++; if (bl_last != 783) begin errors++; $display("FAIL blank_last got %0d want 783", bl_last); end
        checks++; if (rr_n != 640)    begin errors++; $display("FAIL read_width got %0d want 640", rr_n); end
        checks++; if (rr_first != 142) begin errors++; $display("FAIL read_first got %0d want 142", rr_first); end
        checks++; if (rr_last != 781) begin errors++; $display("FAIL read_last got %0d want 781", rr_last); end
    endtask

    task automatic test_mid_reset();
        logic [30:0] e;
        for (int i = 0; i < DH_T && md_h != 300; i++) begin
            tick(1'b0, 1'b0);
            e = q_d.pop_front(); checks++;
            if (obs_d !== e) begin errors++; $display("FAIL walk_d got %h want %h", obs_d, e); end
            q_s.delete(); q_z.delete();
        end
        tick(1'b1, 1'b0);
        e = q_d.pop_front(); checks++;
        if (obs_d !== e) begin errors++; $display("FAIL midreset_d got %h want %h", obs_d, e); end
        q_s.delete(); q_z.delete();
        tick(1'b0, 1'b0);
        checks++;
        if (d_h !== 13'd1 || d_v !== 13'd0) begin errors++; $display("FAIL midreset_restart got (%0d,%0d) want (1,0)", d_h, d_v); end
        q_d.delete(); q_s.delete(); q_z.delete();
        for (int i = 0; i < 2 * SH_T * SV_T && !(ms_h == 10 && ms_v == 6); i++) begin
            tick(1'b0, 1'b0);
            e = q_s.pop_front(); checks++;
            if (obs_s !== e) begin errors++; $display("FAIL walk_s got %h want %h", obs_s, e); end
            q_d.delete(); q_z.delete();
        end
        checks++;
        if (s_h !== 13'd10 || s_v !== 13'd6) begin errors++; $display("FAIL walk_s_pos got (%0d,%0d) want (10,6)", s_h, s_v); end
        tick(1'b0, 1'b1);
        e = q_s.pop_front(); checks++;
        if (obs_s !== e) begin errors++; $display("FAIL midreset_s got %h want %h", obs_s, e); end
        e = q_z.pop_front(); checks++;
        if (obs_z !== e) begin errors++; $display("FAIL midreset_z got %h want %h", obs_z, e); end
        q_d.delete();
    endtask

    task automatic test_blank_lines();
        logic [30:0] e;
        int bad = 0, vs_lo = 0, bl_n = 0, rr_n = 0, zbl_n = 0;
        for (int i = 0; i < 2 * SH_T * SV_T && !(ms_h == SH_T - 1 && ms_v == SV_T - 1); i++) begin
            tick(1'b0, 1'b0);
            e = q_s.pop_front(); checks++;
            if (obs_s !== e) begin errors++; $display("FAIL align_s got %h want %h", obs_s, e); end
            q_d.delete(); q_z.delete();
        end
        for (int i = 0; i < SH_T * SV_T; i++) begin
            tick(1'b0, 1'b0);
            e = q_s.pop_front(); checks++;
            if (obs_s !== e) begin errors++; $display("FAIL frame_s at (%0d,%0d) got %h want %h", ms_h, ms_v, obs_s, e); end
            e = q_z.pop_front(); checks++;
            if (obs_z !== e) begin errors++; $display("FAIL frame_z at (%0d,%0d) got %h want %h", ms_h, ms_v, obs_z, e); end
            checks++;
            if (z_rr !== z_bl) begin errors++; $display("FAIL lead0_eq at (%0d,%0d) got rr=%b want %b", ms_h, ms_v, z_rr, z_bl); end
            q_d.delete();
            if ((ms_v == 4 || ms_v == 9) && (s_bl !== 1'b0 || s_rr !== 1'b0)) bad++;
            if (s_vs === 1'b0) vs_lo++;
            if (s_bl === 1'b1) bl_n++;
            if (s_rr === 1'b1) rr_n++;
            if (z_bl === 1'b1) zbl_n++;
        end
        checks++; if (bad != 0)    begin errors++; $display("FAIL edge_lines got %0d asserts want 0", bad); end
        checks++; if (vs_lo != 36) begin errors++; $display("FAIL vs_width got %0d want 36", vs_lo); end
        checks++; if (bl_n != 32)  begin errors++; $display("FAIL frame_blank got %0d want 32", bl_n); end
        checks++; if (rr_n != 32)  begin errors++; $display("FAIL frame_read got %0d want 32", rr_n); end
        checks++; if (zbl_n != 32) begin errors++; $display("FAIL lead0_blank got %0d want 32", zbl_n); end
    endtask

    task automatic test_frame_wrap();
        logic [30:0] e;
        int   t = 0;
        logic found = 1'b0;
        tick(1'b0, 1'b0);
        e = q_s.pop_front(); checks++;
        if (obs_s !== e) begin errors++; $display("FAIL wrap_s got %h want %h", obs_s, e); end
        checks++;
        if (s_h !== 13'd0 || s_v !== 13'd0 || s_fs !== 1'b1) begin
            errors++; $display("FAIL wrap_pos got (%0d,%0d,fs=%b) want (0,0,fs=1)", s_h, s_v, s_fs);
        end
        q_d.delete(); q_z.delete();
        tick(1'b0, 1'b0);
        checks++;
        if (s_fs !== 1'b0) begin errors++; $display("FAIL fs_width got %b want 0", s_fs); end
        q_d.delete(); q_s.delete(); q_z.delete();
        t = 1;
        while (t < 400 && !found) begin
            tick(1'b0, 1'b0);
            t++;
            e = q_s.pop_front(); checks++;
            if (obs_s !== e) begin errors++; $display("FAIL period_s got %h want %h", obs_s, e); end
            q_d.delete(); q_z.delete();
            if (s_fs === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || t != SH_T * SV_T) begin errors++; $display("FAIL frame_period got %0d want %0d", t, SH_T * SV_T); end
    endtask

    initial begin
        test_reset();
        test_run_to_line();
        test_line();
        test_mid_reset();
        test_blank_lines();
        test_frame_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
